io_input_reg: RTL and testbench
===============================

Name: io_input_reg

Overview:
- Memory-mapped input port block for the pipelined CPU. It is the read-side counterpart of the seven-segment output register.
- Samples board switches and push-buttons, synchronizes and debounces them, and latches button press events.
- Returns the selected port value to the MEM stage on `dataout` for load instructions in the I/O address window.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable synchronized cycles required before a key's debounced level changes (board build overrides to 500000).
- CNT_W, 20, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- io_clk  input  1  I/O clock; all state updates on its rising edge.
- clr  input  1  reset, synchronous, active-high.
- addr  input  32  CPU byte address; only addr[7:2] decoded.
- read_io_enable  input  1  CPU load from I/O space this cycle.
- write_io_enable  input  1  CPU store to I/O space this cycle.
- datain  input  32  CPU store data.
- sw  input  10  raw slide switches, asynchronous.
- key  input  4  raw push-buttons, asynchronous, active-low (pressed = 0).
- dataout  output  32  read data, combinational from registered state and addr.
- key_irq  output  1  registered; 1 when any unmasked press bit is set.

Behaviour:
- Reset:
  - Synchronous to io_clk, active-high (clr = 1 at a rising edge).
  - Clears sync flops (sw to 0, key to 1 = released), debounced key level (released), counters, press register, and mask (all enabled = 4'hF).
  - key_irq = 0. dataout = 0 for every address while clr is held.
- Synchronizers:
  - sw and key each pass through 2 flops; synchronized value is usable 2 cycles after input change.
  - Switches are not debounced.
- Debounce, per key:
  - Keep deb_level (active-high, 1 = pressed).
  - If sync_key_n inverted equals deb_level: counter = 0.
  - Otherwise counter increments. When counter reaches DEBOUNCE_CYCLES-1, deb_level flips and counter = 0.
  - So a clean change propagates to deb_level DEBOUNCE_CYCLES cycles after the synchronized change.
  - A glitch shorter than DEBOUNCE_CYCLES resets the counter and produces no change.
- Press capture:
  - On a deb_level 0->1 transition, set press[i].
  - Press bits are sticky until cleared.
- Address map (addr[7:2]):
  - 6'b110000 (C0h): {27'b0, sw[4:0]} (operand A).
  - 6'b110001 (C4h): {27'b0, sw[9:5]} (operand B).
  - 6'b110010 (C8h): {28'b0, deb_level[3:0]}.
  - 6'b110011 (CCh): {28'b0, press[3:0]}; read-to-clear.
  - 6'b110100 (D0h): {28'b0, mask[3:0]}; writable.
  - Any other address, or read_io_enable = 0: dataout = 0.
- Read-to-clear (CCh):
  - When read_io_enable = 1 at CCh, dataout shows the current press bits that cycle.
  - At the next edge, press clears to 0, except bits whose new press event occurs in that same cycle; those remain 1 (set wins).
- Writes:
  - write_io_enable at D0h loads mask <= datain[3:0].
  - write_io_enable at CCh clears press bits where datain[i] = 1 (W1C); simultaneous new press on the same bit wins.
  - Writes to any other address are ignored. Simultaneous read and write to CCh behaves as read-clear.
- key_irq: registered; key_irq <= |(press & mask), i.e. one cycle after press/mask update.
- Reset mid-debounce: counters discard progress; a key held pressed through reset registers a press DEBOUNCE_CYCLES+2 cycles after clr deasserts.

Test Plan:
- Reset: hold clr 2 cycles with sw = 10'h3FF, key = 4'h0 -> dataout reads 0 at all addresses; key_irq = 0; after release, read D0h = 4'hF.
- Switch path: sw = 10'b10110_01101, read C0h -> 32'h0000000D; read C4h -> 32'h00000016; a change is visible 2 cycles after the input edge.
- Debounce (DEBOUNCE_CYCLES = 16): key[0] low for 10 cycles then high -> C8h stays 0 and CCh stays 0. key[0] held low -> C8h = 1 exactly 18 cycles after the edge; CCh = 1; key_irq = 1 the following cycle.
- Read-to-clear: with press = 4'b0101, read CCh -> dataout = 5, next read = 0. Repeat with a new key[2] press landing in the read cycle -> second read = 4'b0100.
- Mask/W1C: write D0h = 4'b0010, press key[0] -> key_irq stays 0. Press key[1] -> key_irq = 1. Write CCh datain = 2 -> press[1] = 0, key_irq = 0 next cycle.
- Reset mid-operation: assert clr at counter = 8 with key[3] held -> after release C8h = 0 until 18 cycles later, then 4'b1000.

Source files
------------

// File: rtl/io_input_reg_if.sv
// CPU-side bus of the memory-mapped input port block: load/store address, data and the key interrupt.
// The master modport belongs to the CPU MEM stage; the slave modport belongs to io_input_reg.
interface io_input_reg_if;
  logic [31:0] addr;
  logic        read_io_enable;
  logic        write_io_enable;
  logic [31:0] datain;
  logic [31:0] dataout;
  logic        key_irq;

  modport master (
    output addr, read_io_enable, write_io_enable, datain,
    input  dataout, key_irq
  );

  modport slave (
    input  addr, read_io_enable, write_io_enable, datain,
    output dataout, key_irq
  );
endinterface

// File: rtl/io_input_reg.sv
// Memory-mapped switch/button input port: 2-flop sync, per-key debounce, sticky press capture with mask and IRQ.
// Read data is combinational from registered state; a key change reaches deb_level DEBOUNCE_CYCLES+2 edges after the input.
module io_input_reg #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 20
) (
  input  logic          io_clk,
  input  logic          clr,
  input  logic [9:0]    sw,
  input  logic [3:0]    key,
  io_input_reg_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [5:0] A_SW_LO = 6'b110000;
  localparam logic [5:0] A_SW_HI = 6'b110001;
  localparam logic [5:0] A_LEVEL = 6'b110010;
  localparam logic [5:0] A_PRESS = 6'b110011;
  localparam logic [5:0] A_MASK  = 6'b110100;

  logic [9:0]       sw_s1_q, sw_s2_q;
  logic [3:0]       key_s1_q, key_s2_q;
  logic [3:0]       deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       press_q, press_d;
  logic [3:0]       mask_q, mask_d;
  logic             key_irq_q;

  logic [5:0]  word_addr;
  logic [3:0]  key_pressed;
  logic [3:0]  press_clr;
  logic [31:0] rdata;
  logic        unused_bits;

  assign word_addr   = bus.addr[7:2];
  assign key_pressed = ~key_s2_q;
  assign unused_bits = ^{bus.addr[31:8], bus.addr[1:0], bus.datain[31:4]};

  // Any disagreement between the synchronized key and deb_level must persist
  // for DEBOUNCE_CYCLES consecutive cycles; one agreeing cycle restarts the count.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (key_pressed[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        deb_d[i] = ~deb_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    press_clr = '0;
    if (bus.read_io_enable && word_addr == A_PRESS) begin
      press_clr = 4'hF;
    end else if (bus.write_io_enable && word_addr == A_PRESS) begin
      press_clr = bus.datain[3:0];
    end
    // A press landing in the clearing cycle survives the clear.
    press_d = (press_q & ~press_clr) | (deb_d & ~deb_q);

    mask_d = mask_q;
    if (bus.write_io_enable && word_addr == A_MASK) begin
      mask_d = bus.datain[3:0];
    end
  end

  always_ff @(posedge io_clk) begin
    if (clr) begin
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      key_s1_q  <= 4'hF;
      key_s2_q  <= 4'hF;
      deb_q     <= '0;
      press_q   <= '0;
      mask_q    <= 4'hF;
      key_irq_q <= 1'b0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sw_s1_q   <= sw;
      sw_s2_q   <= sw_s1_q;
      key_s1_q  <= key;
      key_s2_q  <= key_s1_q;
      deb_q     <= deb_d;
      press_q   <= press_d;
      mask_q    <= mask_d;
      key_irq_q <= |(press_q & mask_q);
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    rdata = '0;
    if (bus.read_io_enable && !clr) begin
      case (word_addr)
        A_SW_LO: rdata = {27'b0, sw_s2_q[4:0]};
        A_SW_HI: rdata = {27'b0, sw_s2_q[9:5]};
        A_LEVEL: rdata = {28'b0, deb_q};
        A_PRESS: rdata = {28'b0, press_q};
        A_MASK:  rdata = {28'b0, mask_q};
        default: rdata = '0;
      endcase
    end
  end

  assign bus.dataout = rdata;
  assign bus.key_irq = key_irq_q;

endmodule

// File: tb/tb_io_input_reg.sv
// Directed bench for io_input_reg with DEBOUNCE_CYCLES = 16; expected values are hand-computed.
module tb_io_input_reg;
  logic       io_clk = 1'b0;
  logic       clr;
  logic [9:0] sw;
  logic [3:0] key;
  int         n_cmp = 0;
  int         n_bad = 0;

  io_input_reg_if bus ();

  io_input_reg #(.DEBOUNCE_CYCLES(16), .CNT_W(20)) dut (
    .io_clk (io_clk),
    .clr    (clr),
    .sw     (sw),
    .key    (key),
    .bus    (bus)
  );

  always #5 io_clk = ~io_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; inputs change and outputs are sampled 1ns after the edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge io_clk);
      #1;
    end
  endtask

  // Non-destructive read: read enable is dropped again before the next edge.
  task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.addr = a;
    bus.read_io_enable = 1'b1;
    #1;
    check(tag, bus.dataout, exp);
    bus.read_io_enable = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr = a;
    bus.datain = d;
    bus.write_io_enable = 1'b1;
    step(1);
    bus.write_io_enable = 1'b0;
  endtask

  initial begin
    clr = 1'b1;
    sw  = 10'h3FF;
    key = 4'h0;
    bus.addr = '0;
    bus.read_io_enable = 1'b0;
    bus.write_io_enable = 1'b0;
    bus.datain = '0;

    // Reset held: every mapped address reads 0, no interrupt.
    step(2);
    peek("rst_c0", 32'hC0, 32'h0);
    peek("rst_c4", 32'hC4, 32'h0);
    peek("rst_c8", 32'hC8, 32'h0);
    peek("rst_cc", 32'hCC, 32'h0);
    peek("rst_d0", 32'hD0, 32'h0);
    check("rst_irq", {31'b0, bus.key_irq}, 32'h0);
    clr = 1'b0;
    sw  = 10'h000;
    key = 4'hF;
    peek("rst_mask", 32'hD0, 32'hF);

    // Switch path: two-flop latency.
    sw = 10'b10110_01101;
    step(1);
    peek("sw_lat1", 32'hC0, 32'h0);
    step(1);
    peek("sw_lo", 32'hC0, 32'h0000000D);
    peek("sw_hi", 32'hC4, 32'h00000016);
    bus.addr = 32'hC0;
    #1;
    check("no_rd_en", bus.dataout, 32'h0);
    peek("unmapped", 32'hE0, 32'h0);

    // Glitch shorter than the debounce window is rejected.
    key = 4'b1110;
    step(10);
    key = 4'hF;
    step(20);
    peek("glitch_lvl", 32'hC8, 32'h0);
    peek("glitch_prs", 32'hCC, 32'h0);

    // Clean press of key[0]: level rises on the 18th edge, irq one edge later.
    key = 4'b1110;
    step(17);
    peek("deb_early", 32'hC8, 32'h0);
    step(1);
    peek("deb_lvl", 32'hC8, 32'h1);
    peek("deb_prs", 32'hCC, 32'h1);
    check("irq_lag", {31'b0, bus.key_irq}, 32'h0);
    step(1);
    check("irq_set", {31'b0, bus.key_irq}, 32'h1);
    key = 4'hF;
    step(20);

    // Read-to-clear with press = 0101.
    key = 4'b1011;
    step(18);
    key = 4'hF;
    bus.addr = 32'hCC;
    bus.read_io_enable = 1'b1;
    #1;
    check("rc_first", bus.dataout, 32'h5);
    step(1);
    check("rc_second", bus.dataout, 32'h0);
    bus.read_io_enable = 1'b0;
    step(1);
    check("rc_irq_clr", {31'b0, bus.key_irq}, 32'h0);
    step(20);

    // Read-to-clear racing a new key[2] press: set wins.
    key = 4'b1110;
    step(18);
    key = 4'b1010;
    step(17);
    bus.addr = 32'hCC;
    bus.read_io_enable = 1'b1;
    #1;
    check("race_first", bus.dataout, 32'h1);
    step(1);
    check("race_second", bus.dataout, 32'h4);
    bus.read_io_enable = 1'b0;
    key = 4'hF;
    step(20);

    // Mask and W1C.
    wr(32'hCC, 32'h4);
    peek("w1c_all", 32'hCC, 32'h0);
    wr(32'hD0, 32'h2);
    peek("mask_wr", 32'hD0, 32'h2);
    wr(32'hC8, 32'hF);
    peek("wr_ignored", 32'hD0, 32'h2);
    key = 4'b1110;
    step(20);
    check("masked_irq", {31'b0, bus.key_irq}, 32'h0);
    key = 4'b1100;
    step(19);
    peek("two_press", 32'hCC, 32'h3);
    check("unmask_irq", {31'b0, bus.key_irq}, 32'h1);
    wr(32'hCC, 32'h2);
    peek("w1c_bit1", 32'hCC, 32'h1);
    step(1);
    check("w1c_irq", {31'b0, bus.key_irq}, 32'h0);
    key = 4'hF;
    step(20);

    // Reset in the middle of a debounce count on key[3].
    key = 4'b0111;
    step(10);
    clr = 1'b1;
    peek("mid_rst_rd", 32'hC8, 32'h0);
    step(1);
    clr = 1'b0;
    peek("mid_mask", 32'hD0, 32'hF);
    step(17);
    peek("mid_early", 32'hC8, 32'h0);
    step(1);
    peek("mid_lvl", 32'hC8, 32'h8);
    peek("mid_prs", 32'hCC, 32'h8);
    key = 4'hF;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
